// File: rtl/router_ingress.sv
// Ingress FIFO feeding the 4-way address router, issuing strictly in order, one packet per cycle.
// Define ROUTER_INGRESS_CREDIT_EN to gate each issue on a per-destination credit counter.
module router_ingress #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int CREDITS    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic [1:0]               in_addr,
    input  logic [3:0]               credit_ret,
    output logic [DATA_WIDTH-1:0]    din,
    output logic                     din_en,
    output logic [1:0]               addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_WIDTH + 2;

    logic [ENTRY_W-1:0]    mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]      rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [DATA_WIDTH-1:0] din_reg, din_next;
    logic [1:0]            addr_reg, addr_next;
    logic                  din_en_reg;

    logic                  push;
    logic                  pop;
    logic                  not_empty;
    logic                  head_credit_ok;
    logic [1:0]            head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Full is judged on registered occupancy only; a same-cycle pop never frees a slot early.
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign push      = in_valid && in_ready;
    assign not_empty = (count_reg != '0);
    assign pop       = not_empty && head_credit_ok;

    assign {head_addr, head_data} = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto RAM; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_addr, in_data};
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        din_next    = '0;
        addr_next   = '0;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(1);
            din_next    = head_data;
            addr_next   = head_addr;
        end
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            din_reg    <= '0;
            addr_reg   <= '0;
            din_en_reg <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            din_reg    <= din_next;
            addr_reg   <= addr_next;
            din_en_reg <= pop;
        end
    end

    assign din    = din_reg;
    assign addr   = addr_reg;
    assign din_en = din_en_reg;
    assign count  = count_reg;

`ifdef ROUTER_INGRESS_CREDIT_EN
    logic [3:0] credit_nz;

    for (genvar gi = 0; gi < 4; gi++) begin : g_credit
        logic [3:0] credit_reg, credit_next;
        logic       take;
        logic       give;

        assign take = pop && (head_addr == 2'(gi));
        assign give = credit_ret[gi];

        // A simultaneous take and return cancel; a return at full credit is dropped.
        always_comb begin
            credit_next = credit_reg;
            if (take && !give) begin
                credit_next = credit_reg - 4'd1;
            end else if (!take && give && (credit_reg != 4'(CREDITS))) begin
                credit_next = credit_reg + 4'd1;
            end
        end

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                credit_reg <= 4'(CREDITS);
            end else begin
                credit_reg <= credit_next;
            end
        end

        assign credit_nz[gi] = (credit_reg != 4'd0);
    end

    assign head_credit_ok = credit_nz[head_addr];
`else
    logic unused_credit_ret;

    assign unused_credit_ret = ^credit_ret;
    assign head_credit_ok    = 1'b1;
`endif

endmodule

// File: tb/tb_router_ingress.sv
// Randomized bench for router_ingress against a queue-level model of the ingress rules.
// Follows ROUTER_INGRESS_CREDIT_EN so the model gates on credits only when the design does.
module tb_router_ingress;

    localparam int DATA_WIDTH = 32;
    localparam int DEPTH      = 4;
    localparam int CREDITS    = 2;
`ifdef ROUTER_INGRESS_CREDIT_EN
    localparam bit CREDIT_EN  = 1'b1;
`else
    localparam bit CREDIT_EN  = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]            addr;
        logic [DATA_WIDTH-1:0] data;
    } pkt_t;

    logic                   clk;
    logic                   reset;
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic [1:0]             in_addr;
    logic [3:0]             credit_ret;
    logic [DATA_WIDTH-1:0]  din;
    logic                   din_en;
    logic [1:0]             addr;
    logic [$clog2(DEPTH):0] count;

    router_ingress #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .CREDITS   (CREDITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_addr   (in_addr),
        .credit_ret(credit_ret),
        .din       (din),
        .din_en    (din_en),
        .addr      (addr),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   checks = 0;
    int   errors = 0;
    pkt_t model_q[$];
    int   cred[4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        model_q.delete();
        for (int i = 0; i < 4; i++) cred[i] = CREDITS;
    endfunction

    task automatic drive(input bit v, input logic [1:0] a, input logic [DATA_WIDTH-1:0] d,
                         input logic [3:0] r);
        in_valid   = v;
        in_addr    = a;
        in_data    = d;
        credit_ret = r;
    endtask

    // One clock: advance the model on the edge using the inputs the DUT saw, then compare.
    task automatic step();
        int                    occ;
        bit                    do_push;
        bit                    do_issue;
        pkt_t                  head;
        logic [DATA_WIDTH-1:0] e_din;
        logic [1:0]            e_addr;
        @(posedge clk);
        occ      = model_q.size();
        do_push  = in_valid && (occ < DEPTH);
        do_issue = (occ > 0) && (!CREDIT_EN || cred[model_q[0].addr] > 0);
        e_din    = '0;
        e_addr   = '0;
        head     = '0;
        if (do_issue) begin
            head   = model_q.pop_front();
            e_din  = head.data;
            e_addr = head.addr;
        end
        if (CREDIT_EN) begin
            for (int i = 0; i < 4; i++) begin
                if (do_issue && head.addr == 2'(i)) begin
                    if (!credit_ret[i]) cred[i] = cred[i] - 1;
                end else if (credit_ret[i] && cred[i] < CREDITS) begin
                    cred[i] = cred[i] + 1;
                end
            end
        end
        if (do_push) model_q.push_back(pkt_t'{addr: in_addr, data: in_data});
        #1;
        check("din_en", 64'(din_en), 64'(do_issue));
        check("din", 64'(din), 64'(e_din));
        check("addr", 64'(addr), 64'(e_addr));
        check("count", 64'(count), 64'(model_q.size()));
        check("in_ready", 64'(in_ready), 64'(model_q.size() < DEPTH));
        if (din_en) $display("issue addr=%0d data=%08h count=%0d", addr, din, count);
    endtask

    task automatic idle(input int n);
        drive(1'b0, 2'd0, '0, 4'd0);
        repeat (n) step();
    endtask

    task automatic push_pkt(input logic [1:0] a, input logic [DATA_WIDTH-1:0] d);
        drive(1'b1, a, d, 4'd0);
        step();
    endtask

    // Called just after a rising edge; asserts reset mid-cycle to exercise the async path.
    task automatic async_reset();
        #2;
        reset = 1'b1;
        drive(1'b0, 2'd0, '0, 4'd0);
        #1;
        check("rst_din_en", 64'(din_en), 64'd0);
        check("rst_din", 64'(din), 64'd0);
        check("rst_addr", 64'(addr), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        drive(1'b0, 2'd0, '0, 4'd0);
        model_reset();
        @(posedge clk);
        #1;
        async_reset();

        // Single packet: visible for exactly one cycle, two edges after acceptance.
        push_pkt(2'd2, 32'hDEADBEEF);
        check("sp_count1", 64'(count), 64'd1);
        drive(1'b0, 2'd0, '0, 4'd0);
        step();
        check("sp_din", 64'(din), 64'hDEADBEEF);
        check("sp_addr", 64'(addr), 64'd2);
        check("sp_en", 64'(din_en), 64'd1);
        check("sp_count0", 64'(count), 64'd0);
        step();
        check("sp_en_drop", 64'(din_en), 64'd0);

        // Fill toward full on one destination, then return a single credit.
        async_reset();
        for (int i = 0; i < 7; i++) push_pkt(2'd1, $urandom);
        idle(3);
        drive(1'b0, 2'd0, '0, 4'b0010);
        step();
        idle(4);

        // Head-of-line block: addr 3 waits behind a starved addr 0.
        async_reset();
        push_pkt(2'd0, $urandom);
        push_pkt(2'd0, $urandom);
        idle(3);
        push_pkt(2'd0, 32'h0000_00A0);
        push_pkt(2'd3, 32'h0000_00A3);
        idle(4);
        drive(1'b0, 2'd0, '0, 4'b0001);
        step();
        idle(4);

        // Return at full credit, then a return coinciding with an issue on addr 2.
        async_reset();
        drive(1'b0, 2'd0, '0, 4'b0100);
        step();
        push_pkt(2'd2, $urandom);
        drive(1'b0, 2'd0, '0, 4'b0100);
        step();
        push_pkt(2'd2, $urandom);
        push_pkt(2'd2, $urandom);
        push_pkt(2'd2, $urandom);
        idle(4);

        // Reset with entries queued and credits consumed, then a full credit allotment.
        async_reset();
        for (int i = 0; i < 5; i++) push_pkt(2'd1, $urandom);
        async_reset();
        for (int i = 0; i < CREDITS; i++) push_pkt(2'd1, $urandom);
        idle(4);

        // Random traffic with sparse credit returns and occasional resets.
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset();
            end else begin
                drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                      4'($urandom & $urandom));
                step();
            end
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
